// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer and its lock filter.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  // Wide enough that every counter can hold its largest terminal value.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_lock_filter.sv
// Consecutive-high filter: hit_o marks the cycle the input has been high FILTER cycles running.
module lock_filter
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned FILTER = 4,
  parameter int unsigned CW     = cnt_width(FILTER, 1, 1, 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic in_i,
  output logic hit_o
);

  localparam logic [CW-1:0] TERM = CW'(FILTER - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i || !in_i) begin
      cnt_q <= '0;
    end else if (cnt_q != TERM) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign hit_o = en_i & in_i & (cnt_q == TERM);

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES reset domains in index order after a hold and a filtered lock.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned LOCK_FILTER = 4,
  parameter int unsigned STAGE_DELAY = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lock_in,
  input  logic                  sw_reset_req,
  output logic [NUM_STAGES-1:0] reset_out,
  output logic                  ready
);

  localparam int unsigned CW = cnt_width(NUM_STAGES, HOLD_CYCLES, LOCK_FILTER, STAGE_DELAY);
  localparam logic [CW-1:0] HOLD_TERM  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_TERM = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] LAST_STAGE = CW'(NUM_STAGES - 1);

  seq_state_e            state_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         stage_q;
  logic [NUM_STAGES-1:0] rst_q;
  logic                  ready_q;
  logic                  lock_hit;

  lock_filter #(
    .FILTER (LOCK_FILTER),
    .CW     (CW)
  ) u_lock_filter (
    .clk_i (clk),
    .rst_i (reset),
    .en_i  ((state_q == WAIT_LOCK) && !sw_reset_req),
    .in_i  (lock_in),
    .hit_o (lock_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      stage_q <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          rst_q   <= '1;
          ready_q <= 1'b0;
          if (sw_reset_req) begin
            cnt_q <= '0;
          end else if (cnt_q == HOLD_TERM) begin
            cnt_q   <= '0;
            state_q <= WAIT_LOCK;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT_LOCK: begin
          if (sw_reset_req) begin
            state_q <= HOLD;
            cnt_q   <= '0;
          end else if (lock_hit) begin
            state_q <= RELEASE;
            cnt_q   <= '0;
            stage_q <= '0;
          end
        end
        RELEASE, RUN: begin
          // Abort is checked first so it overrides a release landing on the same edge.
          if (sw_reset_req || !lock_in) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            stage_q <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
          end else if (state_q == RELEASE) begin
            if (cnt_q == DELAY_TERM) begin
              cnt_q <= '0;
              for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                if (CW'(i) == stage_q) rst_q[i] <= 1'b0;
              end
              if (stage_q == LAST_STAGE) begin
                state_q <= RUN;
                ready_q <= 1'b1;
              end else begin
                stage_q <= stage_q + CW'(1);
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: state_q <= HOLD;
      endcase
    end
  end

  assign reset_out = rst_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Checks a default and a minimal-parameter reset_sequencer against an edge-timing model.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lock_in = 1'b1;
  logic       sw_reset_req = 1'b0;
  logic [3:0] ro_a;
  logic       rdy_a;
  logic [0:0] ro_b;
  logic       rdy_b;

  int n_pass = 0;
  int n_total = 0;
  int e = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_STAGES (4), .HOLD_CYCLES (8), .LOCK_FILTER (4), .STAGE_DELAY (16)
  ) dut_a (
    .clk (clk), .reset (reset), .lock_in (lock_in), .sw_reset_req (sw_reset_req),
    .reset_out (ro_a), .ready (rdy_a)
  );

  reset_sequencer #(
    .NUM_STAGES (1), .HOLD_CYCLES (1), .LOCK_FILTER (1), .STAGE_DELAY (1)
  ) dut_b (
    .clk (clk), .reset (reset), .lock_in (lock_in), .sw_reset_req (sw_reset_req),
    .reset_out (ro_b), .ready (rdy_b)
  );

  // Model: phase (0 hold, 1 wait for lock, 2 releasing/running) plus elapsed cycles;
  // released stage count is derived arithmetically from elapsed time.
  int m_mode[2];
  int m_t[2];
  int m_run[2];
  int P_NS[2] = '{4, 1};
  int P_H[2]  = '{8, 1};
  int P_LF[2] = '{4, 1};
  int P_SD[2] = '{16, 1};

  task automatic model_edge(input int i);
    if (reset) begin
      m_mode[i] = 0; m_t[i] = 0; m_run[i] = 0;
    end else if (m_mode[i] == 0) begin
      if (sw_reset_req) m_t[i] = 0;
      else if (m_t[i] == P_H[i] - 1) begin m_mode[i] = 1; m_t[i] = 0; m_run[i] = 0; end
      else m_t[i]++;
    end else if (m_mode[i] == 1) begin
      if (sw_reset_req) begin m_mode[i] = 0; m_t[i] = 0; end
      else begin
        m_run[i] = lock_in ? m_run[i] + 1 : 0;
        if (m_run[i] >= P_LF[i]) begin m_mode[i] = 2; m_t[i] = 0; end
      end
    end else begin
      if (sw_reset_req || !lock_in) begin m_mode[i] = 0; m_t[i] = 0; end
      else if (m_t[i] < P_NS[i] * P_SD[i]) m_t[i]++;
    end
  endtask

  function automatic int released(input int i);
    return (m_mode[i] == 2) ? m_t[i] / P_SD[i] : 0;
  endfunction

  function automatic logic [3:0] exp_ro(input int i);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < P_NS[i]; k++) r[k] = (k >= released(i));
    return r;
  endfunction

  function automatic logic exp_rdy(input int i);
    return released(i) == P_NS[i];
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %b expected %b", name, e, got, exp);
  endtask

  task automatic tick();
    logic [3:0] xa, xb;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    e++;
    #1;
    xa = exp_ro(0);
    xb = exp_ro(1);
    check("model_ro_a", ro_a, xa);
    check("model_rdy_a", {3'b0, rdy_a}, {3'b0, exp_rdy(0)});
    check("model_ro_b", {3'b0, ro_b}, {3'b0, xb[0]});
    check("model_rdy_b", {3'b0, rdy_b}, {3'b0, exp_rdy(1)});
  endtask

  task automatic run_to(input int n);
    while (e < n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sw_reset_req = 1'b0;
    repeat (3) tick();
    check("reset_ro_a", ro_a, 4'b1111);
    check("reset_rdy_a", {3'b0, rdy_a}, 4'b0000);
    check("reset_ro_b", {3'b0, ro_b}, 4'b0001);
    reset = 1'b0;
    e = 0;
  endtask

  typedef struct {
    int         edge_n;
    int         inst;
    logic [3:0] ro;
    logic       rdy;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl = '{
      '{2,  1, 4'b0001, 1'b0}, '{3,  1, 4'b0000, 1'b1},
      '{27, 0, 4'b1111, 1'b0}, '{28, 0, 4'b1110, 1'b0},
      '{43, 0, 4'b1110, 1'b0}, '{44, 0, 4'b1100, 1'b0},
      '{59, 0, 4'b1100, 1'b0}, '{60, 0, 4'b1000, 1'b0},
      '{75, 0, 4'b1000, 1'b0}, '{76, 0, 4'b0000, 1'b1},
      '{1,  0, 4'b1111, 1'b0}, '{12, 0, 4'b1111, 1'b0},
      '{80, 0, 4'b0000, 1'b1}
    };

    // Nominal sequence for both parameter sets, compared against the vector table.
    lock_in = 1'b1;
    do_reset();
    for (int n = 1; n <= 80; n++) begin
      tick();
      foreach (tbl[j]) begin
        if (tbl[j].edge_n == e) begin
          if (tbl[j].inst == 0) begin
            check("tbl_ro_a", ro_a, tbl[j].ro);
            check("tbl_rdy_a", {3'b0, rdy_a}, {3'b0, tbl[j].rdy});
          end else begin
            check("tbl_ro_b", {3'b0, ro_b}, tbl[j].ro);
            check("tbl_rdy_b", {3'b0, rdy_b}, {3'b0, tbl[j].rdy});
          end
        end
      end
    end

    // Single-cycle lock loss in RUN restarts the whole sequence.
    lock_in = 1'b0;
    tick();
    check("lockloss_ro", ro_a, 4'b1111);
    check("lockloss_rdy", {3'b0, rdy_a}, 4'b0000);
    lock_in = 1'b1;
    run_to(108);
    check("relock_pre", ro_a, 4'b1111);
    tick();
    check("relock_stage0", ro_a, 4'b1110);

    // Late lock: release starts four edges after lock rises.
    lock_in = 1'b0;
    do_reset();
    run_to(20);
    lock_in = 1'b1;
    run_to(39);
    check("latelock_pre", ro_a, 4'b1111);
    tick();
    check("latelock_stage0", ro_a, 4'b1110);

    // Lock glitch inside WAIT_LOCK restarts the filter.
    lock_in = 1'b1;
    do_reset();
    run_to(9);
    lock_in = 1'b0;
    tick();
    lock_in = 1'b1;
    run_to(29);
    check("glitch_pre", ro_a, 4'b1111);
    tick();
    check("glitch_stage0", ro_a, 4'b1110);

    // Software request on the stage-1 release edge, then a pulse inside HOLD.
    do_reset();
    run_to(43);
    check("sw_pre", ro_a, 4'b1110);
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    check("sw_abort_ro", ro_a, 4'b1111);
    check("sw_abort_rdy", {3'b0, rdy_a}, 4'b0000);
    run_to(46);
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    run_to(74);
    check("holdext_pre", ro_a, 4'b1111);
    tick();
    check("holdext_stage0", ro_a, 4'b1110);

    // Reset mid-release wins over simultaneous sw request and lock loss.
    do_reset();
    run_to(49);
    check("midrel_pre", ro_a, 4'b1100);
    reset = 1'b1;
    sw_reset_req = 1'b1;
    lock_in = 1'b0;
    tick();
    check("midrel_ro", ro_a, 4'b1111);
    check("midrel_rdy", {3'b0, rdy_a}, 4'b0000);
    tick();
    reset = 1'b0;
    sw_reset_req = 1'b0;
    lock_in = 1'b1;
    e = 0;
    run_to(27);
    check("after_rst_pre", ro_a, 4'b1111);
    tick();
    check("after_rst_stage0", ro_a, 4'b1110);

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      reset        = ($urandom_range(0, 499) == 0);
      sw_reset_req = ($urandom_range(0, 299) == 0);
      lock_in      = ($urandom_range(0, 149) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
